// File: rtl/npc_bus_pkg.sv
// Shared definitions for the core memory-port arbiter: FSM encoding,
// master IDs and default bus widths.
package npc_bus_pkg;

  localparam int unsigned AW_DEF = 32;
  localparam int unsigned DW_DEF = 32;

  localparam logic MID_IFU = 1'b0;
  localparam logic MID_LSU = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_e;

endpackage

// File: rtl/npc_rr_pick.sv
// Two-way combinational winner selection: round-robin on last_grant,
// or fixed LSU priority on a tie.
module npc_rr_pick
  import npc_bus_pkg::*;
(
  input  logic [1:0] req,
  input  logic       last_grant,
  input  logic       lsu_prio,
  output logic [1:0] gnt_c,
  output logic       id_c
);

  always_comb begin
    id_c  = MID_IFU;
    gnt_c = 2'b00;
    if (req == 2'b11) begin
      id_c = lsu_prio ? MID_LSU : ~last_grant;
    end else if (req[1]) begin
      id_c = MID_LSU;
    end
    if (|req) begin
      gnt_c = (id_c == MID_LSU) ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/npc_mem_arbiter.sv
// Non-pipelined arbiter sharing one memory port between IFU (M0) and LSU (M1);
// one transaction in flight, response routed only to the owning master.
module npc_mem_arbiter
  import npc_bus_pkg::*;
#(
  parameter int unsigned AW       = AW_DEF,
  parameter int unsigned DW       = DW_DEF,
  parameter int unsigned LSU_PRIO = 0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              m0_req_valid,
  output logic              m0_req_ready,
  input  logic [AW-1:0]     m0_addr,
  input  logic              m0_wen,
  input  logic [DW-1:0]     m0_wdata,
  input  logic [DW/8-1:0]   m0_wstrb,
  output logic              m0_resp_valid,
  input  logic              m0_resp_ready,
  output logic [DW-1:0]     m0_rdata,
  output logic              m0_resp_err,
  input  logic              m1_req_valid,
  output logic              m1_req_ready,
  input  logic [AW-1:0]     m1_addr,
  input  logic              m1_wen,
  input  logic [DW-1:0]     m1_wdata,
  input  logic [DW/8-1:0]   m1_wstrb,
  output logic              m1_resp_valid,
  input  logic              m1_resp_ready,
  output logic [DW-1:0]     m1_rdata,
  output logic              m1_resp_err,
  output logic              s_req_valid,
  input  logic              s_req_ready,
  output logic [AW-1:0]     s_addr,
  output logic              s_wen,
  output logic [DW-1:0]     s_wdata,
  output logic [DW/8-1:0]   s_wstrb,
  input  logic              s_resp_valid,
  output logic              s_resp_ready,
  input  logic [DW-1:0]     s_rdata,
  input  logic              s_resp_err
);

  localparam int unsigned SW = DW / 8;

  state_e          state_q, state_d;
  logic            owner_q, owner_d;
  logic            last_grant_q, last_grant_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic            wen_q, wen_d;
  logic [DW-1:0]   wdata_q, wdata_d;
  logic [SW-1:0]   wstrb_q, wstrb_d;

  logic [1:0]      gnt;
  logic            pick_id;
  logic            owner_ready;

  npc_rr_pick u_pick (
    .req        ({m1_req_valid, m0_req_valid}),
    .last_grant (last_grant_q),
    .lsu_prio   (LSU_PRIO != 0),
    .gnt_c      (gnt),
    .id_c       (pick_id)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      owner_q      <= MID_IFU;
      last_grant_q <= MID_LSU;
      addr_q       <= '0;
      wen_q        <= 1'b0;
      wdata_q      <= '0;
      wstrb_q      <= '0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      addr_q       <= addr_d;
      wen_q        <= wen_d;
      wdata_q      <= wdata_d;
      wstrb_q      <= wstrb_d;
    end
  end

  // Next-state, request capture and response routing.
  always_comb begin
    state_d       = state_q;
    owner_d       = owner_q;
    last_grant_d  = last_grant_q;
    addr_d        = addr_q;
    wen_d         = wen_q;
    wdata_d       = wdata_q;
    wstrb_d       = wstrb_q;
    owner_ready   = 1'b0;
    m0_req_ready  = 1'b0;
    m1_req_ready  = 1'b0;
    s_req_valid   = 1'b0;
    s_resp_ready  = 1'b0;
    m0_resp_valid = 1'b0;
    m0_rdata      = '0;
    m0_resp_err   = 1'b0;
    m1_resp_valid = 1'b0;
    m1_rdata      = '0;
    m1_resp_err   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        // Ready is held off while reset is asserted so no handshake is seen.
        if (!reset && (|gnt)) begin
          m0_req_ready = gnt[0];
          m1_req_ready = gnt[1];
          owner_d      = pick_id;
          addr_d       = (pick_id == MID_LSU) ? m1_addr  : m0_addr;
          wen_d        = (pick_id == MID_LSU) ? m1_wen   : m0_wen;
          wdata_d      = (pick_id == MID_LSU) ? m1_wdata : m0_wdata;
          wstrb_d      = (pick_id == MID_LSU) ? m1_wstrb : m0_wstrb;
          state_d      = ST_REQ;
        end
      end
      ST_REQ: begin
        s_req_valid = 1'b1;
        if (s_req_ready) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        owner_ready  = (owner_q == MID_LSU) ? m1_resp_ready : m0_resp_ready;
        s_resp_ready = owner_ready;
        if (owner_q == MID_LSU) begin
          m1_resp_valid = s_resp_valid;
          m1_rdata      = s_rdata;
          m1_resp_err   = s_resp_err;
        end else begin
          m0_resp_valid = s_resp_valid;
          m0_rdata      = s_rdata;
          m0_resp_err   = s_resp_err;
        end
        if (s_resp_valid && owner_ready) begin
          last_grant_d = owner_q;
          state_d      = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign s_addr  = addr_q;
  assign s_wen   = wen_q;
  assign s_wdata = wdata_q;
  assign s_wstrb = wstrb_q;

endmodule

// File: tb/tb_npc_mem_arbiter.sv
// Directed bench for npc_mem_arbiter: a round-robin instance and an
// LSU-priority instance share every input.
module tb_npc_mem_arbiter;

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req_valid, m1_req_valid;
  logic [31:0] m0_addr, m1_addr;
  logic        m0_wen, m1_wen;
  logic [31:0] m0_wdata, m1_wdata;
  logic [3:0]  m0_wstrb, m1_wstrb;
  logic        m0_resp_ready, m1_resp_ready;
  logic        s_req_ready, s_resp_valid, s_resp_err;
  logic [31:0] s_rdata;

  logic        m0_req_ready, m1_req_ready, m0_resp_valid, m1_resp_valid;
  logic [31:0] m0_rdata, m1_rdata;
  logic        m0_resp_err, m1_resp_err;
  logic        s_req_valid, s_wen, s_resp_ready;
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_wstrb;

  logic        p_m0_req_ready, p_m1_req_ready, p_m0_resp_valid, p_m1_resp_valid;
  logic [31:0] p_m0_rdata, p_m1_rdata;
  logic        p_m0_resp_err, p_m1_resp_err;
  logic        p_s_req_valid, p_s_wen, p_s_resp_ready;
  logic [31:0] p_s_addr, p_s_wdata;
  logic [3:0]  p_s_wstrb;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  npc_mem_arbiter #(.AW(32), .DW(32), .LSU_PRIO(0)) dut (
    .clk(clk), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(m0_req_ready), .m0_addr(m0_addr),
    .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_resp_valid(m0_resp_valid), .m0_resp_ready(m0_resp_ready),
    .m0_rdata(m0_rdata), .m0_resp_err(m0_resp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_resp_valid(m1_resp_valid), .m1_resp_ready(m1_resp_ready),
    .m1_rdata(m1_rdata), .m1_resp_err(m1_resp_err),
    .s_req_valid(s_req_valid), .s_req_ready(s_req_ready), .s_addr(s_addr),
    .s_wen(s_wen), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
    .s_resp_valid(s_resp_valid), .s_resp_ready(s_resp_ready),
    .s_rdata(s_rdata), .s_resp_err(s_resp_err)
  );

  npc_mem_arbiter #(.AW(32), .DW(32), .LSU_PRIO(1)) dut_prio (
    .clk(clk), .reset(reset),
    .m0_req_valid(m0_req_valid), .m0_req_ready(p_m0_req_ready), .m0_addr(m0_addr),
    .m0_wen(m0_wen), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
    .m0_resp_valid(p_m0_resp_valid), .m0_resp_ready(m0_resp_ready),
    .m0_rdata(p_m0_rdata), .m0_resp_err(p_m0_resp_err),
    .m1_req_valid(m1_req_valid), .m1_req_ready(p_m1_req_ready), .m1_addr(m1_addr),
    .m1_wen(m1_wen), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
    .m1_resp_valid(p_m1_resp_valid), .m1_resp_ready(m1_resp_ready),
    .m1_rdata(p_m1_rdata), .m1_resp_err(p_m1_resp_err),
    .s_req_valid(p_s_req_valid), .s_req_ready(s_req_ready), .s_addr(p_s_addr),
    .s_wen(p_s_wen), .s_wdata(p_s_wdata), .s_wstrb(p_s_wstrb),
    .s_resp_valid(s_resp_valid), .s_resp_ready(p_s_resp_ready),
    .s_rdata(s_rdata), .s_resp_err(s_resp_err)
  );

  task automatic clear_inputs;
    m0_req_valid = 1'b0; m1_req_valid = 1'b0;
    m0_addr = '0; m1_addr = '0; m0_wen = 1'b0; m1_wen = 1'b0;
    m0_wdata = '0; m1_wdata = '0; m0_wstrb = '0; m1_wstrb = '0;
    m0_resp_ready = 1'b0; m1_resp_ready = 1'b0;
    s_req_ready = 1'b0; s_resp_valid = 1'b0; s_resp_err = 1'b0; s_rdata = '0;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    clear_inputs();
    m0_req_valid = 1'b1; m1_req_valid = 1'b1; s_resp_valid = 1'b1;
    m0_addr = 32'h1234_5678;
    @(negedge clk);
    vectors++; if (m0_req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_m0_req_ready: got %b want 0", m0_req_ready); end
    vectors++; if (m1_req_ready !== 1'b0) begin miscompares++; $display("FAIL reset_m1_req_ready: got %b want 0", m1_req_ready); end
    vectors++; if (s_req_valid !== 1'b0) begin miscompares++; $display("FAIL reset_s_req_valid: got %b want 0", s_req_valid); end
    vectors++; if (s_resp_ready !== 1'b0) begin miscompares++; $display("FAIL reset_s_resp_ready: got %b want 0", s_resp_ready); end
    vectors++; if (s_addr !== 32'h0) begin miscompares++; $display("FAIL reset_s_addr: got %h want 0", s_addr); end
    vectors++; if (s_wstrb !== 4'h0) begin miscompares++; $display("FAIL reset_s_wstrb: got %h want 0", s_wstrb); end
    vectors++; if (m0_resp_valid !== 1'b0 || m0_rdata !== 32'h0) begin miscompares++; $display("FAIL reset_m0_resp: got %b/%h want 0/0", m0_resp_valid, m0_rdata); end
    clear_inputs();
    next_cycle();
    reset = 1'b0;
  endtask

  task automatic test_single_read;
    m0_req_valid = 1'b1; m0_addr = 32'h8000_0000; m0_wen = 1'b0;
    s_req_ready = 1'b1; m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
    @(negedge clk);
    vectors++; if (m0_req_ready !== 1'b1) begin miscompares++; $display("FAIL rd_m0_req_ready: got %b want 1", m0_req_ready); end
    vectors++; if (m1_req_ready !== 1'b0) begin miscompares++; $display("FAIL rd_m1_req_ready: got %b want 0", m1_req_ready); end
    next_cycle();
    m0_req_valid = 1'b0; m0_addr = 32'h0;
    @(negedge clk);
    vectors++; if (s_req_valid !== 1'b1) begin miscompares++; $display("FAIL rd_s_req_valid: got %b want 1", s_req_valid); end
    vectors++; if (s_addr !== 32'h8000_0000) begin miscompares++; $display("FAIL rd_s_addr: got %h want 80000000", s_addr); end
    vectors++; if (s_wen !== 1'b0) begin miscompares++; $display("FAIL rd_s_wen: got %b want 0", s_wen); end
    next_cycle();
    s_resp_valid = 1'b1; s_rdata = 32'h0010_0093;
    @(negedge clk);
    vectors++; if (m0_resp_valid !== 1'b1) begin miscompares++; $display("FAIL rd_m0_resp_valid: got %b want 1", m0_resp_valid); end
    vectors++; if (m0_rdata !== 32'h0010_0093) begin miscompares++; $display("FAIL rd_m0_rdata: got %h want 00100093", m0_rdata); end
    vectors++; if (m1_resp_valid !== 1'b0 || m1_rdata !== 32'h0) begin miscompares++; $display("FAIL rd_m1_resp: got %b/%h want 0/0", m1_resp_valid, m1_rdata); end
    vectors++; if (s_resp_ready !== 1'b1) begin miscompares++; $display("FAIL rd_s_resp_ready: got %b want 1", s_resp_ready); end
    vectors++; if (s_req_valid !== 1'b0) begin miscompares++; $display("FAIL rd_s_req_valid_resp: got %b want 0", s_req_valid); end
    next_cycle();
    s_resp_valid = 1'b0;
    @(negedge clk);
    vectors++; if (m0_resp_valid !== 1'b0 || s_req_valid !== 1'b0) begin miscompares++; $display("FAIL rd_idle_after: got %b/%b want 0/0", m0_resp_valid, s_req_valid); end
    next_cycle();
  endtask

  task automatic test_tie;
    logic g_rr [8];
    logic g_pr [8];
    int   n_rr = 0;
    int   n_pr = 0;
    int   both = 0;
    reset = 1'b1;
    next_cycle();
    reset = 1'b0;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    m0_addr = 32'h0000_0100; m1_addr = 32'h0000_0200;
    s_req_ready = 1'b1; s_resp_valid = 1'b1;
    m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (m0_req_ready && m1_req_ready) both++;
      if (m0_req_ready || m1_req_ready) begin
        if (n_rr < 8) g_rr[n_rr] = m1_req_ready;
        n_rr++;
      end
      if (p_m0_req_ready || p_m1_req_ready) begin
        if (n_pr < 8) g_pr[n_pr] = p_m1_req_ready;
        n_pr++;
      end
      next_cycle();
    end
    clear_inputs();
    vectors++; if (both !== 0) begin miscompares++; $display("FAIL tie_double_grant: got %0d want 0", both); end
    vectors++; if (n_rr !== 4) begin miscompares++; $display("FAIL tie_rr_count: got %0d want 4", n_rr); end
    vectors++; if (n_pr !== 4) begin miscompares++; $display("FAIL tie_prio_count: got %0d want 4", n_pr); end
    for (int k = 0; k < 4; k++) begin
      vectors++; if (g_rr[k] !== k[0]) begin miscompares++; $display("FAIL tie_rr_grant%0d: got M%0d want M%0d", k, g_rr[k], k[0]); end
      vectors++; if (g_pr[k] !== 1'b1) begin miscompares++; $display("FAIL tie_prio_grant%0d: got M%0d want M1", k, g_pr[k]); end
    end
    next_cycle();
  endtask

  task automatic test_backpressure;
    m0_req_valid = 1'b1; m0_addr = 32'h0000_1000; m0_wen = 1'b1;
    m0_wdata = 32'hdead_beef; m0_wstrb = 4'hf;
    s_req_ready = 1'b0; m0_resp_ready = 1'b0;
    @(negedge clk);
    vectors++; if (m0_req_ready !== 1'b1) begin miscompares++; $display("FAIL bp_m0_req_ready: got %b want 1", m0_req_ready); end
    next_cycle();
    m0_req_valid = 1'b0; m0_addr = 32'hffff_ffff; m0_wdata = 32'h0; m0_wstrb = 4'h0;
    s_resp_valid = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      vectors++; if (s_req_valid !== 1'b1) begin miscompares++; $display("FAIL bp_s_req_valid%0d: got %b want 1", c, s_req_valid); end
      vectors++; if (s_addr !== 32'h0000_1000 || s_wdata !== 32'hdead_beef || s_wstrb !== 4'hf) begin
        miscompares++; $display("FAIL bp_s_payload%0d: got %h/%h/%h want 00001000/deadbeef/f", c, s_addr, s_wdata, s_wstrb);
      end
      vectors++; if (s_resp_ready !== 1'b0 || m0_resp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_early_resp%0d: got %b/%b want 0/0", c, s_resp_ready, m0_resp_valid); end
      next_cycle();
    end
    s_req_ready = 1'b1;
    next_cycle();
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      vectors++; if (s_resp_ready !== 1'b0) begin miscompares++; $display("FAIL bp_s_resp_ready%0d: got %b want 0", c, s_resp_ready); end
      vectors++; if (m0_resp_valid !== 1'b1) begin miscompares++; $display("FAIL bp_m0_resp_valid%0d: got %b want 1", c, m0_resp_valid); end
      next_cycle();
    end
    m0_resp_ready = 1'b1;
    @(negedge clk);
    vectors++; if (s_resp_ready !== 1'b1) begin miscompares++; $display("FAIL bp_s_resp_ready_rel: got %b want 1", s_resp_ready); end
    next_cycle();
    s_resp_valid = 1'b0;
    @(negedge clk);
    vectors++; if (s_req_valid !== 1'b0 || m0_resp_valid !== 1'b0) begin miscompares++; $display("FAIL bp_idle_after: got %b/%b want 0/0", s_req_valid, m0_resp_valid); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_write_err;
    m1_req_valid = 1'b1; m1_addr = 32'ha000_03f8; m1_wen = 1'b1;
    m1_wdata = 32'h0000_0041; m1_wstrb = 4'b0001;
    s_req_ready = 1'b1; m1_resp_ready = 1'b1; m0_resp_ready = 1'b1;
    @(negedge clk);
    vectors++; if (m1_req_ready !== 1'b1 || m0_req_ready !== 1'b0) begin miscompares++; $display("FAIL we_req_ready: got m0=%b m1=%b want m0=0 m1=1", m0_req_ready, m1_req_ready); end
    next_cycle();
    m1_req_valid = 1'b0;
    @(negedge clk);
    vectors++; if (s_addr !== 32'ha000_03f8 || s_wen !== 1'b1 || s_wdata !== 32'h41 || s_wstrb !== 4'b0001) begin
      miscompares++; $display("FAIL we_s_payload: got %h/%b/%h/%h want a00003f8/1/00000041/1", s_addr, s_wen, s_wdata, s_wstrb);
    end
    next_cycle();
    s_resp_valid = 1'b1; s_resp_err = 1'b1; s_rdata = 32'h1234_5678;
    @(negedge clk);
    vectors++; if (m1_resp_valid !== 1'b1 || m1_resp_err !== 1'b1) begin miscompares++; $display("FAIL we_m1_resp: got %b/%b want 1/1", m1_resp_valid, m1_resp_err); end
    vectors++; if (m1_rdata !== 32'h1234_5678) begin miscompares++; $display("FAIL we_m1_rdata: got %h want 12345678", m1_rdata); end
    vectors++; if (m0_resp_valid !== 1'b0 || m0_resp_err !== 1'b0 || m0_rdata !== 32'h0) begin
      miscompares++; $display("FAIL we_m0_quiet: got %b/%b/%h want 0/0/0", m0_resp_valid, m0_resp_err, m0_rdata);
    end
    next_cycle();
    clear_inputs();
    next_cycle();
  endtask

  task automatic test_reset_mid;
    m0_req_valid = 1'b1; m0_addr = 32'h0000_2000; s_req_ready = 1'b0;
    next_cycle();
    m0_req_valid = 1'b0;
    @(negedge clk);
    vectors++; if (s_req_valid !== 1'b1) begin miscompares++; $display("FAIL rm_in_req: got %b want 1", s_req_valid); end
    #1 reset = 1'b1;
    #1;
    vectors++; if (s_req_valid !== 1'b0) begin miscompares++; $display("FAIL rm_async_valid: got %b want 0", s_req_valid); end
    vectors++; if (s_addr !== 32'h0) begin miscompares++; $display("FAIL rm_async_addr: got %h want 0", s_addr); end
    next_cycle();
    reset = 1'b0;
    m0_req_valid = 1'b1; m1_req_valid = 1'b1;
    @(negedge clk);
    vectors++; if (m0_req_ready !== 1'b1 || m1_req_ready !== 1'b0) begin miscompares++; $display("FAIL rm_first_tie: got m0=%b m1=%b want m0=1 m1=0", m0_req_ready, m1_req_ready); end
    vectors++; if (p_m1_req_ready !== 1'b1 || p_m0_req_ready !== 1'b0) begin miscompares++; $display("FAIL rm_prio_tie: got m0=%b m1=%b want m0=0 m1=1", p_m0_req_ready, p_m1_req_ready); end
    next_cycle();
    clear_inputs();
    s_req_ready = 1'b1; s_resp_valid = 1'b1; m0_resp_ready = 1'b1; m1_resp_ready = 1'b1;
    repeat (3) next_cycle();
    clear_inputs();
  endtask

  initial begin
    test_reset();
    test_single_read();
    test_tie();
    test_backpressure();
    test_write_err();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
